// File: rtl/writeback_arbiter_if.sv
// writeback_arbiter_if: bundles the pipeline writeback, multdiv handshake,
// register-file write port and decode busy-check signals of writeback_arbiter.
// slave  = arbiter side, master = surrounding pipeline / test driver side.
interface writeback_arbiter_if;
  // Pipeline (MEM/WB) writeback
  logic        wb_valid;
  logic [4:0]  wb_wsel;
  logic [31:0] wb_wdat;
  // Multdiv result handshake
  logic        md_valid;
  logic        md_ready;
  logic [4:0]  md_wsel;
  logic [31:0] md_wdat;
  // Register-file write port
  logic        WEN;
  logic [4:0]  wsel;
  logic [31:0] wdat;
  // Status / decode hazard check
  logic        md_pending;
  logic [4:0]  chk_sel1;
  logic [4:0]  chk_sel2;
  logic        busy_hit1;
  logic        busy_hit2;

  modport slave (
    input  wb_valid, wb_wsel, wb_wdat,
    input  md_valid, md_wsel, md_wdat,
    output md_ready,
    output WEN, wsel, wdat,
    output md_pending,
    input  chk_sel1, chk_sel2,
    output busy_hit1, busy_hit2
  );

  modport master (
    output wb_valid, wb_wsel, wb_wdat,
    output md_valid, md_wsel, md_wdat,
    input  md_ready,
    input  WEN, wsel, wdat,
    input  md_pending,
    output chk_sel1, chk_sel2,
    input  busy_hit1, busy_hit2
  );
endinterface

// File: rtl/writeback_arbiter.sv
// writeback_arbiter: owns the single register-file write port. The in-order
// pipeline writeback always wins; multdiv results wait in a DEPTH-entry FIFO
// and drain oldest-first in cycles with no effective pipeline write.
// Also flags source registers that still have a write in flight.
// Optional feature macro: WB_MD_BYPASS_EN -- a multdiv result arriving with the
// FIFO empty and no pipeline write goes straight to the output register.
module writeback_arbiter #(
  parameter int DEPTH = 2  // multdiv FIFO entries, power of two, >= 2
) (
  input  logic                CLK,
  input  logic                nRST,
  writeback_arbiter_if.slave  bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic [4:0]  wsel;
    logic [31:0] wdat;
  } md_entry_t;

  md_entry_t       mem_q [DEPTH];
  logic [PW-1:0]   head_q, head_d;
  logic [PW-1:0]   tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;

  logic            wen_q, wen_d;
  logic [4:0]      wsel_q, wsel_d;
  logic [31:0]     wdat_q, wdat_d;

  logic            wb_eff;   // pipeline write that actually targets a register
  logic            md_fire;  // handshake completes this cycle
  logic            md_take;  // handshake carries a real destination
  logic            bypass;   // multdiv result goes straight to the output
  logic            push;
  logic            pop;
  logic            hit1, hit2;

  // Status flags come from registered count only, so md_ready never
  // depends combinationally on md_valid.
  assign bus.md_ready   = (count_q != FULL);
  assign bus.md_pending = (count_q != '0);

  assign wb_eff  = bus.wb_valid && (bus.wb_wsel != 5'd0);
  assign md_fire = bus.md_valid && bus.md_ready;
  assign md_take = md_fire && (bus.md_wsel != 5'd0);
  assign pop     = !wb_eff && bus.md_pending;

`ifdef WB_MD_BYPASS_EN
  assign bypass = md_take && !wb_eff && (count_q == '0);
`else
  assign bypass = 1'b0;
`endif

  assign push = md_take && !bypass;

  assign bus.WEN  = wen_q;
  assign bus.wsel = wsel_q;
  assign bus.wdat = wdat_q;

  // Output register next state: pipeline first, then FIFO head, then bypass.
  always_comb begin
    // NOTE: every comb output gets a default before any branch, so no path
    // leaves it unassigned and no latch is inferred.
    wen_d  = 1'b0;
    wsel_d = wsel_q;
    wdat_d = wdat_q;
    if (wb_eff) begin
      wen_d  = 1'b1;
      wsel_d = bus.wb_wsel;
      wdat_d = bus.wb_wdat;
    end else if (pop) begin
      wen_d  = 1'b1;
      wsel_d = mem_q[head_q].wsel;
      wdat_d = mem_q[head_q].wdat;
    end else if (bypass) begin
      wen_d  = 1'b1;
      wsel_d = bus.md_wsel;
      wdat_d = bus.md_wdat;
    end
  end

  // FIFO pointer and occupancy next state; pointers wrap naturally at DEPTH.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (pop)  head_d = head_q + 1'b1;
    if (push) tail_d = tail_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Control state: output register and FIFO bookkeeping.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wen_q   <= 1'b0;
      wsel_q  <= 5'd0;
      wdat_q  <= 32'd0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      wen_q   <= wen_d;
      wsel_q  <= wsel_d;
      wdat_q  <= wdat_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // FIFO storage write at the tail.
  // NOTE: storage is deliberately not reset; occupancy (count/head) decides
  // which entries are live, so stale data is never observed.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem_q[tail_q] <= '{wsel: bus.md_wsel, wdat: bus.md_wdat};
    end
  end

  // Busy check: register 0 is never busy; otherwise any live FIFO entry or
  // the pending output write to the same register marks it busy.
  always_comb begin
    logic [PW-1:0] age;
    logic          live;
    age  = '0;
    live = 1'b0;
    hit1 = wen_q && (wsel_q == bus.chk_sel1);
    hit2 = wen_q && (wsel_q == bus.chk_sel2);
    for (int i = 0; i < DEPTH; i++) begin
      age  = PW'(i) - head_q;
      live = ({1'b0, age} < count_q);
      if (live && (mem_q[i].wsel == bus.chk_sel1)) hit1 = 1'b1;
      if (live && (mem_q[i].wsel == bus.chk_sel2)) hit2 = 1'b1;
    end
    bus.busy_hit1 = hit1 && (bus.chk_sel1 != 5'd0);
    bus.busy_hit2 = hit2 && (bus.chk_sel2 != 5'd0);
  end

endmodule
